// File: rtl/mem_read_arbiter.sv
// Shared AXI read-channel sequencer: arbitrates instruction/data requesters, issues one AR at a time, steers R beats.
// Optional read-after-write line hazard check on the data side: define MEM_READ_RAW_CHECK_EN.
module mem_read_arbiter #(
    parameter int unsigned LINE_WORD_NUM = 16,
    parameter int unsigned STARVE_LIMIT  = 4,
    parameter logic [3:0]  ID_INST       = 4'd0,
    parameter logic [3:0]  ID_DATA       = 4'd1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_i_req_valid,
    input  logic [31:0] i_i_addr,
    input  logic [3:0]  i_i_len,
    input  logic [2:0]  i_i_size,
    output logic        o_i_req_ready,
    output logic        o_i_rvalid,
    output logic        o_i_rlast,
    output logic [31:0] o_i_rdata,
    input  logic        i_d_req_valid,
    input  logic [31:0] i_d_addr,
    input  logic [3:0]  i_d_len,
    input  logic [2:0]  i_d_size,
    output logic        o_d_req_ready,
    output logic        o_d_rvalid,
    output logic        o_d_rlast,
    output logic [31:0] o_d_rdata,
    input  logic        i_write_busy,
    input  logic [31:0] i_write_addr,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        o_idle,
    output logic        o_err
);

    localparam int unsigned LINE_LSB = $clog2(LINE_WORD_NUM) + 2;
    localparam int unsigned STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

    state_e              state_q, state_d;
    logic [3:0]          arid_q, arid_d;
    logic [31:0]         araddr_q, araddr_d;
    logic [3:0]          arlen_q, arlen_d;
    logic [2:0]          arsize_q, arsize_d;
    logic                owner_d_q, owner_d_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [3:0]          beat_q, beat_d;
    logic                err_q, err_d;

    logic d_hazard, d_elig, starve_hit, grant_i, grant_d, fwd;
    logic unused_write;

    // Data request is held off while the write queue still owns the same cache line.
`ifdef MEM_READ_RAW_CHECK_EN
    assign d_hazard = i_write_busy && (i_d_addr[31:LINE_LSB] == i_write_addr[31:LINE_LSB]);
`else
    assign d_hazard = 1'b0;
`endif
    assign unused_write = ^{i_write_busy, i_write_addr};

    assign d_elig     = i_d_req_valid && !d_hazard;
    assign starve_hit = (starve_q >= STARVE_W'(STARVE_LIMIT));

    always_comb begin
        state_d   = state_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        owner_d_d = owner_d_q;
        starve_d  = starve_q;
        beat_d    = beat_q;
        err_d     = err_q;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (d_elig && !(i_i_req_valid && starve_hit)) begin
                    grant_d = 1'b1;
                end else if (i_i_req_valid) begin
                    grant_i = 1'b1;
                end
                if (grant_d) begin
                    state_d   = S_ADDR;
                    arid_d    = ID_DATA;
                    araddr_d  = i_d_addr;
                    arlen_d   = i_d_len;
                    arsize_d  = i_d_size;
                    owner_d_d = 1'b1;
                    beat_d    = 4'd0;
                    if (i_i_req_valid && !starve_hit) begin
                        starve_d = STARVE_W'(starve_q + 1'b1);
                    end
                end else if (grant_i) begin
                    state_d   = S_ADDR;
                    arid_d    = ID_INST;
                    araddr_d  = i_i_addr;
                    arlen_d   = i_i_len;
                    arsize_d  = i_i_size;
                    owner_d_d = 1'b0;
                    beat_d    = 4'd0;
                    starve_d  = '0;
                end
            end
            S_ADDR: begin
                if (arready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // Foreign-id beats are swallowed and flagged; they do not advance the burst.
                if (rvalid) begin
                    if (rid != arid_q) begin
                        err_d = 1'b1;
                    end else begin
                        if (rresp != 2'b00) begin
                            err_d = 1'b1;
                        end
                        beat_d = 4'(beat_q + 4'd1);
                        if (rlast) begin
                            if (beat_q != arlen_q) begin
                                err_d = 1'b1;
                            end
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            arid_q    <= 4'd0;
            araddr_q  <= 32'd0;
            arlen_q   <= 4'd0;
            arsize_q  <= 3'd0;
            owner_d_q <= 1'b0;
            starve_q  <= '0;
            beat_q    <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            owner_d_q <= owner_d_d;
            starve_q  <= starve_d;
            beat_q    <= beat_d;
            err_q     <= err_d;
        end
    end

    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arsize  = arsize_q;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (state_q == S_ADDR);
    assign rready  = (state_q == S_DATA);

    assign o_i_req_ready = grant_i && i_rst_n;
    assign o_d_req_ready = grant_d && i_rst_n;

    assign fwd        = rready && rvalid && (rid == arid_q);
    assign o_i_rvalid = fwd && !owner_d_q;
    assign o_d_rvalid = fwd && owner_d_q;
    assign o_i_rlast  = o_i_rvalid && rlast;
    assign o_d_rlast  = o_d_rvalid && rlast;
    assign o_i_rdata  = rdata;
    assign o_d_rdata  = rdata;

    assign o_idle = (state_q == S_IDLE) && !i_i_req_valid && !i_d_req_valid;
    assign o_err  = err_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: single refill, starvation rotation, AR stall, error handling, reset abort, RAW hazard.
module tb_mem_read_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_i_req_valid, i_d_req_valid;
    logic [31:0] i_i_addr, i_d_addr;
    logic [3:0]  i_i_len, i_d_len;
    logic [2:0]  i_i_size, i_d_size;
    logic        o_i_req_ready, o_i_rvalid, o_i_rlast;
    logic        o_d_req_ready, o_d_rvalid, o_d_rlast;
    logic [31:0] o_i_rdata, o_d_rdata;
    logic        i_write_busy;
    logic [31:0] i_write_addr;
    logic [3:0]  arid, arlen, arcache;
    logic [31:0] araddr;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        o_idle, o_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    mem_read_arbiter dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_i_req_valid(i_i_req_valid), .i_i_addr(i_i_addr), .i_i_len(i_i_len), .i_i_size(i_i_size),
        .o_i_req_ready(o_i_req_ready), .o_i_rvalid(o_i_rvalid), .o_i_rlast(o_i_rlast), .o_i_rdata(o_i_rdata),
        .i_d_req_valid(i_d_req_valid), .i_d_addr(i_d_addr), .i_d_len(i_d_len), .i_d_size(i_d_size),
        .o_d_req_ready(o_d_req_ready), .o_d_rvalid(o_d_rvalid), .o_d_rlast(o_d_rlast), .o_d_rdata(o_d_rdata),
        .i_write_busy(i_write_busy), .i_write_addr(i_write_addr),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .o_idle(o_idle), .o_err(o_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] seq;
        i_rst_n = 1'b0;
        i_i_req_valid = 0; i_i_addr = 0; i_i_len = 0; i_i_size = 0;
        i_d_req_valid = 0; i_d_addr = 0; i_d_len = 0; i_d_size = 0;
        i_write_busy = 0; i_write_addr = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        #1;
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_araddr", araddr, 32'd0);
        check("rst_arburst", 32'(arburst), 32'd1);
        check("rst_idle", 32'(o_idle), 32'd1);
        check("rst_err", 32'(o_err), 32'd0);
        tick(); tick();
        i_rst_n = 1'b1;
        tick();

        // Single 16-beat instruction refill
        i_i_req_valid = 1; i_i_addr = 32'h1FC0_0000; i_i_len = 4'd15; i_i_size = 3'd2;
        #1;
        check("t1_i_ready", 32'(o_i_req_ready), 32'd1);
        check("t1_d_ready", 32'(o_d_req_ready), 32'd0);
        check("t1_arvalid_pre", 32'(arvalid), 32'd0);
        tick();
        i_i_req_valid = 0;
        check("t1_arvalid", 32'(arvalid), 32'd1);
        check("t1_arid", 32'(arid), 32'd0);
        check("t1_arlen", 32'(arlen), 32'd15);
        check("t1_araddr", araddr, 32'h1FC0_0000);
        check("t1_arsize", 32'(arsize), 32'd2);
        arready = 1;
        tick();
        arready = 0;
        check("t1_rready", 32'(rready), 32'd1);
        for (int b = 0; b < 16; b++) begin
            rvalid = 1; rid = 4'd0; rdata = 32'hA000_0000 + 32'(b); rlast = (b == 15);
            #1;
            check("t1_i_rvalid", 32'(o_i_rvalid), 32'd1);
            check("t1_i_rdata", o_i_rdata, 32'hA000_0000 + 32'(b));
            check("t1_i_rlast", 32'(o_i_rlast), (b == 15) ? 32'd1 : 32'd0);
            check("t1_d_rvalid", 32'(o_d_rvalid), 32'd0);
            tick();
        end
        rvalid = 0; rlast = 0;
        #1;
        check("t1_idle_after", 32'(o_idle), 32'd1);
        check("t1_err", 32'(o_err), 32'd0);

        // Both requesters always valid: D,D,D,D,I,D,D,D,D,I (bit k=1 means data grant)
        seq = 10'b0111101111;
        i_i_req_valid = 1; i_i_addr = 32'h0000_1000; i_i_len = 0;
        i_d_req_valid = 1; i_d_addr = 32'h0000_2000; i_d_len = 0;
        #1;
        for (int k = 0; k < 10; k++) begin
            check("t2_grant_d", 32'(o_d_req_ready), 32'(seq[k]));
            check("t2_grant_i", 32'(o_i_req_ready), 32'(!seq[k]));
            tick();
            check("t2_arid", 32'(arid), 32'(seq[k]));
            arready = 1;
            tick();
            arready = 0;
            rvalid = 1; rlast = 1; rid = seq[k] ? 4'd1 : 4'd0; rdata = 32'(k);
            #1;
            check("t2_fwd", 32'(seq[k] ? o_d_rvalid : o_i_rvalid), 32'd1);
            tick();
            rvalid = 0; rlast = 0;
            #1;
        end
        i_i_req_valid = 0; i_d_req_valid = 0;

        // AR stall: fields stable, no rready until handshake
        i_d_req_valid = 1; i_d_addr = 32'h8000_0100; i_d_len = 4'd3; i_d_size = 3'd2;
        #1;
        check("t3_d_ready", 32'(o_d_req_ready), 32'd1);
        tick();
        i_d_req_valid = 0; i_d_addr = 32'hDEAD_BEEF; i_d_len = 4'd9;
        for (int c = 0; c < 5; c++) begin
            check("t3_arvalid", 32'(arvalid), 32'd1);
            check("t3_araddr", araddr, 32'h8000_0100);
            check("t3_arlen", 32'(arlen), 32'd3);
            check("t3_arid", 32'(arid), 32'd1);
            check("t3_rready", 32'(rready), 32'd0);
            tick();
        end
        arready = 1;
        tick();
        arready = 0;
        check("t3_rready_on", 32'(rready), 32'd1);
        rvalid = 1; rid = 4'd3; rdata = 32'h5555_5555;
        #1;
        check("t3_badid_d", 32'(o_d_rvalid), 32'd0);
        check("t3_badid_i", 32'(o_i_rvalid), 32'd0);
        check("t3_badid_rready", 32'(rready), 32'd1);
        tick();
        check("t3_err_id", 32'(o_err), 32'd1);
        rid = 4'd1; rresp = 2'b10; rdata = 32'h1111_0000;
        #1;
        check("t3_slverr_fwd", 32'(o_d_rvalid), 32'd1);
        tick();
        rresp = 2'b00;
        check("t3_err_held", 32'(o_err), 32'd1);
        for (int b = 1; b < 4; b++) begin
            rdata = 32'h1111_0000 + 32'(b); rlast = (b == 3);
            #1;
            check("t3_d_rvalid", 32'(o_d_rvalid), 32'd1);
            check("t3_d_rlast", 32'(o_d_rlast), (b == 3) ? 32'd1 : 32'd0);
            tick();
        end
        rvalid = 0; rlast = 0;
        #1;
        check("t3_idle", 32'(o_idle), 32'd1);
        check("t3_err_sticky", 32'(o_err), 32'd1);

        // Reset during beat 7 of 16
        i_i_req_valid = 1; i_i_addr = 32'h1FC0_0040; i_i_len = 4'd15;
        tick();
        i_i_req_valid = 0;
        arready = 1;
        tick();
        arready = 0;
        for (int b = 0; b < 6; b++) begin
            rvalid = 1; rid = 4'd0; rdata = 32'(b);
            tick();
        end
        rdata = 32'd6;
        #1;
        check("t4_beat7_fwd", 32'(o_i_rvalid), 32'd1);
        i_rst_n = 0;
        #1;
        check("t4_arvalid", 32'(arvalid), 32'd0);
        check("t4_rready", 32'(rready), 32'd0);
        check("t4_i_rvalid", 32'(o_i_rvalid), 32'd0);
        check("t4_err", 32'(o_err), 32'd0);
        check("t4_idle", 32'(o_idle), 32'd1);
        rvalid = 0;
        tick();
        i_rst_n = 1;
        tick();

        // rlast arriving early on a 2-beat burst
        i_d_req_valid = 1; i_d_addr = 32'h8000_0200; i_d_len = 4'd1;
        tick();
        i_d_req_valid = 0;
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rid = 4'd1; rlast = 1;
        #1;
        check("t5_d_rlast", 32'(o_d_rlast), 32'd1);
        tick();
        rvalid = 0; rlast = 0;
        #1;
        check("t5_err", 32'(o_err), 32'd1);
        check("t5_idle", 32'(o_idle), 32'd1);

        // Data request to the line the write queue still holds
        i_write_busy = 1; i_write_addr = 32'h8000_0040;
        i_d_req_valid = 1; i_d_addr = 32'h8000_0044; i_d_len = 0;
        i_i_req_valid = 1; i_i_addr = 32'h1FC0_0080; i_i_len = 0;
        #1;
`ifdef MEM_READ_RAW_CHECK_EN
        check("t6_i_first", 32'(o_i_req_ready), 32'd1);
        check("t6_d_blocked", 32'(o_d_req_ready), 32'd0);
        tick();
        i_i_req_valid = 0;
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rlast = 1; rid = 4'd0;
        tick();
        rvalid = 0; rlast = 0;
        #1;
        check("t6_d_still_blocked", 32'(o_d_req_ready), 32'd0);
        i_write_busy = 0;
        #1;
        check("t6_d_granted", 32'(o_d_req_ready), 32'd1);
`else
        check("t6_d_first", 32'(o_d_req_ready), 32'd1);
        check("t6_i_waits", 32'(o_i_req_ready), 32'd0);
`endif
        tick();
        i_d_req_valid = 0; i_i_req_valid = 0; i_write_busy = 0;
        check("t6_arid", 32'(arid), 32'd1);
        check("t6_araddr", araddr, 32'h8000_0044);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
